pipeline_perf_counter: RTL and testbench

Synthesizable run controller and event-counter bank for the pipelined CPU. It generalises the bench-side cycle/stall/flush counting into hardware: a parametrised number of event channels, saturating counters, a bounded run window, and a registered read-back port. It sits beside `CPU`. Hazard/flush/retire strobes from the pipeline feed `event_i`; the bench or a debug bus reads results through `rd_sel_i`/`rd_data_o`.

---
 rtl/pipeline_perf_counter.sv | 136 +++++++++++++
 tb/tb_pipeline_perf_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_perf_counter.sv
// -----------------------------------------------------------------------------
// pipeline_perf_counter
//
// Run controller and event-counter bank for the pipelined CPU. A bounded run
// window (or a free-running window when MAX_CYCLES = 0) counts clock cycles
// and masked per-channel event strobes into saturating counters, which are
// read back through a registered select port.
//
// Ports
//   clk_i         clock, all state updates on the rising edge
//   rst_n_i       asynchronous active-low reset
//   start_i       begin a run from IDLE or DONE (level-sampled)
//   clear_i       synchronous clear of all counters and saturation flags
//   event_i       per-channel event strobes, one count per asserted cycle
//   event_mask_i  per-channel count enable (1 = count)
//   rd_sel_i      0..NUM_EVENTS-1 event counter, NUM_EVENTS cycle counter
//   rd_data_o     registered read data (value before the sampling edge)
//   running_o     high while in RUN
//   done_o        high while in DONE
//   finish_o      one-cycle pulse after the RUN->DONE edge
//   sat_o         sticky saturation flags, bit NUM_EVENTS = cycle counter
// -----------------------------------------------------------------------------
module pipeline_perf_counter #(
  parameter int NUM_EVENTS = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int MAX_CYCLES = 64,
  parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] event_mask_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic                  running_o,
  output logic                  done_o,
  output logic                  finish_o,
  output logic [NUM_EVENTS:0]   sat_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int                   NCNT    = NUM_EVENTS + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] WINDOW  = CNT_WIDTH'(MAX_CYCLES);

  // Counter bank: indices 0..NUM_EVENTS-1 are event channels, the last entry
  // is the cycle counter, so all counters share one update rule.
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d [NCNT];
  logic [NUM_EVENTS:0]  sat_q, sat_d;
  logic [NUM_EVENTS:0]  inc;
  logic                 finish_d;
  logic                 finish_q;
  logic [CNT_WIDTH-1:0] rd_d;
  logic                 start_take;

  assign inc        = {1'b1, event_i & event_mask_i};
  assign start_take = (state_q != S_RUN) && start_i;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    finish_d = 1'b0;

    // Start and clear both restart the bank; clear beats the RUN increment.
    if (start_take || clear_i) begin
      for (int k = 0; k < NCNT; k++) cnt_d[k] = '0;
      sat_d = '0;
    end else if (state_q == S_RUN) begin
      for (int k = 0; k < NCNT; k++) begin
        if (inc[k]) begin
          if (cnt_q[k] == CNT_MAX) sat_d[k] = 1'b1;
          else                     cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        // Leave on the edge where the cycle counter reaches the window length;
        // a clear on that edge zeroes the counter instead, so no exit.
        if (MAX_CYCLES != 0 && !clear_i && cnt_d[NUM_EVENTS] == WINDOW) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux looks at the pre-update counter values.
  always_comb begin
    rd_d = '0;
    if (int'(rd_sel_i) < NCNT) rd_d = cnt_q[rd_sel_i];
  end

  // NOTE: the counters are ordinary flops, not a RAM, so they are cleared by
  // the async reset like any other state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
      sat_q     <= '0;
      finish_q  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values
      // regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      finish_q  <= finish_d;
      rd_data_o <= rd_d;
    end
  end

  assign running_o = (state_q == S_RUN);
  assign done_o    = (state_q == S_DONE);
  assign finish_o  = finish_q;
  assign sat_o     = sat_q;

endmodule

// File: tb/tb_pipeline_perf_counter.sv
module tb_pipeline_perf_counter;

  localparam int NE   = 2;
  localparam int W    = 32;
  localparam int MAXC = 64;
  localparam int SW   = 2;
  localparam int SWD  = 4;   // counter width of the saturation instance

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, clear;
  logic [NE-1:0] ev, mask;
  logic [SW-1:0] rd_sel;
  logic [W-1:0]  rd_data;
  logic          running, done, finish;
  logic [NE:0]   sat;

  logic           s_start, s_clear;
  logic [NE-1:0]  s_ev;
  logic [SW-1:0]  s_sel;
  logic [SWD-1:0] s_rd;
  logic           s_running, s_done, s_finish;
  logic [NE:0]    s_sat;

  pipeline_perf_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(W), .MAX_CYCLES(MAXC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear),
    .event_i(ev), .event_mask_i(mask), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .running_o(running), .done_o(done), .finish_o(finish), .sat_o(sat)
  );

  pipeline_perf_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(SWD), .MAX_CYCLES(0)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(s_start), .clear_i(s_clear),
    .event_i(s_ev), .event_mask_i(2'b11), .rd_sel_i(s_sel), .rd_data_o(s_rd),
    .running_o(s_running), .done_o(s_done), .finish_o(s_finish), .sat_o(s_sat)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [W-1:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a select, queue its expected value, and compare once the
  // registered read data appears after the next edge.
  task automatic rd(input int sel, input logic [W-1:0] exp, input string tag);
    exp_t e;
    rd_sel = SW'(sel);
    e.tag  = tag;
    e.exp  = exp;
    sb.push_back(e);
    step();
    e = sb.pop_front();
    check(e.tag, rd_data, e.exp);
  endtask

  initial begin
    int fin;
    int fin_at;
    int n;

    rst_n = 1'b0; start = 1'b0; clear = 1'b0; ev = '0; mask = 2'b11; rd_sel = '0;
    s_start = 1'b0; s_clear = 1'b0; s_ev = '0; s_sel = '0;
    step(); step();
    check("rst_rd", rd_data, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_finish", finish, 0);
    check("rst_sat", sat, 0);
    rst_n = 1'b1;
    step();

    // ---------------- basic run ----------------
    start = 1'b1;
    step();
    start = 1'b0;
    check("basic_running", running, 1);
    fin = 0; fin_at = -1;
    for (int i = 0; i < MAXC; i++) begin
      ev = '0;
      if (i inside {0, 10, 20, 30, 63}) ev[0] = 1'b1;
      if (i inside {5, 6, 40})          ev[1] = 1'b1;
      step();
      if (finish) begin
        fin++;
        if (fin_at < 0) fin_at = i;
      end
    end
    ev = '0;
    check("basic_done", done, 1);
    check("basic_running_off", running, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (finish) fin++;
    end
    check("basic_finish_count", fin, 1);
    check("basic_finish_at", fin_at, 63);
    rd(0, 5,  "basic_sel0");
    rd(1, 3,  "basic_sel1");
    rd(2, 64, "basic_sel2");
    rd(3, 0,  "basic_sel_oor");

    // ---------------- mask, frozen DONE ----------------
    mask  = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    ev    = 2'b11;
    for (int i = 0; i < MAXC; i++) step();
    check("mask_done", done, 1);
    for (int i = 0; i < 5; i++) step();
    rd(0, 64, "mask_sel0");
    rd(1, 0,  "mask_sel1");
    rd(2, 64, "mask_sel2");
    check("mask_still_done", done, 1);
    ev   = '0;
    mask = 2'b11;

    // ---------------- clear priority ----------------
    start = 1'b1;
    step();
    start = 1'b0;
    ev    = 2'b01;
    step(); step(); step();       // event counter 0 now 3
    clear = 1'b1;                 // clear together with an event
    step();
    clear = 1'b0;
    check("clr_running", running, 1);
    ev = 2'b01;
    rd(0, 0, "clr_sel0_after_clear");
    ev = 2'b00;
    rd(0, 1, "clr_sel0_after_event");
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    check("clr_done", done, 1);
    rd(2, 64, "clr_sel2");

    // ---------------- reset mid-run ----------------
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ev = {1'b0, i[0]};
      rd_sel = 2'd0;
      step();
    end
    ev    = '0;
    rst_n = 1'b0;
    #1;
    check("rstm_running", running, 0);
    check("rstm_done", done, 0);
    check("rstm_finish", finish, 0);
    check("rstm_sat", sat, 0);
    check("rstm_rd", rd_data, 0);
    step();
    check("rstm_finish_held", finish, 0);
    rst_n = 1'b1;
    step();
    check("rstm_idle", running, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    fin = 0;
    for (int i = 0; i < MAXC; i++) begin
      ev = (i % 9 == 0) ? 2'b10 : 2'b00;
      step();
      if (finish) fin++;
    end
    ev = '0;
    check("rstm_finish_count", fin, 1);
    rd(0, 0,  "rstm_sel0");
    rd(1, 8,  "rstm_sel1");
    rd(2, 64, "rstm_sel2");

    // ---------------- restart from DONE ----------------
    start = 1'b1;
    step();
    start = 1'b0;
    rd(1, 0, "restart_sel1_cleared");
    n = 1;
    while (!finish && n < 100) begin
      step();
      n++;
    end
    check("restart_finish_at", n, 64);
    rd(3, 0, "restart_sel_oor");

    // ---------------- saturation (width 4, free-running) ----------------
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    s_ev    = 2'b01;
    for (int i = 0; i < 20; i++) step();
    s_sel = 2'd0;
    step();
    check("sat_sel0", s_rd, 15);
    check("sat_flags", s_sat, 3'b101);
    check("sat_running", s_running, 1);
    check("sat_not_done", s_done, 0);
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    s_ev    = '0;
    check("sat_flags_cleared", s_sat, 0);
    step();
    check("sat_sel0_cleared", s_rd, 0);
    check("sat_running_after_clear", s_running, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
